ddr2_controller_dmaster_b2p_converter: RTL
==========================================

Name: ddr2_controller_dmaster_b2p_converter

Overview:
Avalon-ST bytes-to-packets converter for the debug master path.
- Decodes the escaped 8-bit byte stream (SOP/EOP/channel/escape control codes) arriving from the host link into packetised data beats carrying startofpacket, endofpacket and channel.
- Sits between the byte-stream source and the channel adapter feeding the DDR2 debug master.
- It is the receive-side counterpart of the packets-to-bytes path.

Parameters:
SOP_CODE, 8'h7A, control byte marking that the next data byte starts a packet.
EOP_CODE, 8'h7B, control byte marking that the next data byte ends a packet.
CHN_CODE, 8'h7C, control byte; the next decoded byte is a channel number.
ESC_CODE, 8'h7D, escape; the next byte is XORed with ESC_XOR and taken literally.
ESC_XOR, 8'h20, escape mask.

Ports:
clk  input  1  single clock, all logic rising-edge.
reset_n  input  1  asynchronous active-low reset.
in_ready  output  1  byte sink ready.
in_valid  input  1  byte valid.
in_data  input  8  encoded byte.
out_ready  input  1  downstream ready.
out_valid  output  1  decoded beat valid.
out_data  output  8  decoded data byte.
out_startofpacket  output  1  beat is first of packet.
out_endofpacket  output  1  beat is last of packet.
out_channel  output  8  channel of beat.

Behaviour:
Interface and reset
- One clock, clk. reset_n is asynchronous, active-low.
- Reset: out_valid, out_data, out_startofpacket, out_endofpacket, out_channel = 0. Internal flags esc_pend, chn_pend, sop_pend, eop_pend = 0. Channel register = 0.

Handshake
- in_ready = !out_valid || out_ready (combinational).
- A byte is accepted when in_valid && in_ready.
- The output register holds all out_* signals stable while out_valid && !out_ready.
- On out_valid && out_ready with no new data byte accepted in the same cycle, out_valid clears next cycle.

Decode of an accepted byte b (priority order)
1. esc_pend=1: v = b ^ ESC_XOR; clear esc_pend. If chn_pend, channel register <= v and clear chn_pend. Otherwise emit v as data.
2. b==ESC_CODE: set esc_pend.
3. chn_pend=1: channel register <= b; clear chn_pend. Raw SOP/EOP/CHN codes here are taken as channel values.
4. b==SOP_CODE: set sop_pend, clear eop_pend (restarts packet framing).
5. b==EOP_CODE: set eop_pend.
6. b==CHN_CODE: set chn_pend.
7. Otherwise emit b as data.

Emit
- Next edge: out_valid=1, out_data=value, out_startofpacket=sop_pend, out_endofpacket=eop_pend, out_channel=channel register (including any update made in the same cycle).
- Then clear sop_pend and eop_pend.

Latency and throughput
- Latency: 1 cycle from accepted data byte to out_valid.
- Throughput: 1 beat/cycle with out_ready=1.
- Control bytes consume one input cycle, emit nothing, and do not disturb a held output beat.

Boundary conditions
- Repeated SOP_CODE: idempotent.
- EOP_CODE then SOP_CODE with no data between: eop cleared.
- ESC followed by ESC: second byte decodes as 8'h5D data.
- Escape or channel pending persists across in_valid gaps and backpressure stalls.
- Reset mid-packet: all pending state and the held beat are discarded immediately (async).

Optional Feature:
Macro B2P_CHANNEL_EN.
- Defined: channel decode as above; out_channel driven from the channel register.
- Undefined: out_channel tied to 0, no channel register. CHN_CODE still sets chn_pend, so the following byte (escape-decoded if escaped) is consumed and discarded, keeping framing aligned.

Test Plan:
1. Stream 7A,01,02,7B,03 with out_ready=1 -> beats 01(sop=1), 02, 03(eop=1) on consecutive output cycles, 1-cycle latency.
2. Stream 7A,7D,5A,7B,7D,5D -> beats 7A(sop=1), 7D(eop=1).
3. With B2P_CHANNEL_EN: 7C,05,7A,AA,7B,BB -> AA sop ch=05, BB eop ch=05. Then 7C,7D,5C,CC -> CC ch=7C. Without the macro -> same data, ch=0.
4. Hold out_ready=0 after first beat 11 and present 22 -> out_* stay at 11, in_ready=0. Release -> 22 follows next cycle.
5. Assert reset_n low mid-packet after 7A,7D -> all outputs 0 immediately. Post-reset 41 -> beat 41 with sop=0 (escape and sop flags cleared).
6. Interleave in_valid gaps between 7D and 5A -> still decodes to 7A data.

Source files
------------

// File: rtl/ddr2_controller_dmaster_b2p_converter.sv
// ddr2_controller_dmaster_b2p_converter: decodes an escaped byte stream into packet beats; B2P_CHANNEL_EN enables channel decode
module ddr2_controller_dmaster_b2p_converter #(
  parameter logic [7:0] SOP_CODE = 8'h7A,
  parameter logic [7:0] EOP_CODE = 8'h7B,
  parameter logic [7:0] CHN_CODE = 8'h7C,
  parameter logic [7:0] ESC_CODE = 8'h7D,
  parameter logic [7:0] ESC_XOR  = 8'h20
) (
  input  logic       clk,
  input  logic       reset_n,
  output logic       in_ready,
  input  logic       in_valid,
  input  logic [7:0] in_data,
  input  logic       out_ready,
  output logic       out_valid,
  output logic [7:0] out_data,
  output logic       out_startofpacket,
  output logic       out_endofpacket,
  output logic [7:0] out_channel
);
  logic esc_pend, chn_pend, sop_pend, eop_pend;
  logic accept, raw, frame, emit, chn_load;
  logic [7:0] v;
  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign raw      = accept && !esc_pend;
  assign frame    = raw && !chn_pend;
  assign v        = esc_pend ? in_data ^ ESC_XOR : in_data;
  assign chn_load = accept && chn_pend && !(raw && in_data == ESC_CODE);
  assign emit     = accept && !chn_pend &&
                    (esc_pend || !(in_data inside {ESC_CODE, SOP_CODE, EOP_CODE, CHN_CODE}));
  // decode-state flags; an SOP code restarts framing and drops a stale EOP
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      esc_pend <= 1'b0;
      chn_pend <= 1'b0;
      sop_pend <= 1'b0;
      eop_pend <= 1'b0;
    end else begin
      esc_pend <= accept ? raw && in_data == ESC_CODE : esc_pend;
      chn_pend <= chn_load ? 1'b0 : chn_pend || (raw && in_data == CHN_CODE);
      sop_pend <= emit ? 1'b0 : sop_pend || (frame && in_data == SOP_CODE);
      eop_pend <= (emit || (frame && in_data == SOP_CODE)) ? 1'b0
                : eop_pend || (frame && in_data == EOP_CODE);
    end
  // output beat register: load on emit, drop valid once consumed, hold under backpressure
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      out_valid         <= 1'b0;
      out_data          <= 8'h00;
      out_startofpacket <= 1'b0;
      out_endofpacket   <= 1'b0;
    end else if (emit) begin
      out_valid         <= 1'b1;
      out_data          <= v;
      out_startofpacket <= sop_pend;
      out_endofpacket   <= eop_pend;
    end else if (out_ready) begin
      out_valid         <= 1'b0;
    end
`ifdef B2P_CHANNEL_EN
  logic [7:0] chn_reg, chn_next;
  assign chn_next = chn_load ? v : chn_reg;
  // channel register and per-beat channel, so a same-cycle update reaches the beat
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      chn_reg     <= 8'h00;
      out_channel <= 8'h00;
    end else begin
      chn_reg     <= chn_next;
      out_channel <= emit ? chn_next : out_channel;
    end
`else
  assign out_channel = 8'h00;
`endif
endmodule
